// File: rtl/mem_burst_splitter_pkg.sv
// Shared types and constants for the memory command path that feeds memory_controller.
// Beat size is fixed here; the minus-one length encoding lives in beats_to_len.
package mem_ctrl_pkg;

  localparam int BEAT_BYTES  = 16;
  localparam int BEAT_SHIFT  = 4;
  localparam int ADDR_W      = 32;
  localparam int LEN_W       = 16;
  localparam int BURST_LEN_W = 8;
  localparam int CHUNK_W     = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // 256 beats encodes as 8'hFF; callers never pass 0 while a burst is presented.
  function automatic logic [BURST_LEN_W-1:0] beats_to_len(input logic [CHUNK_W-1:0] beats);
    return BURST_LEN_W'(beats - CHUNK_W'(1));
  endfunction

endpackage

// File: rtl/mem_burst_splitter_if.sv
// Request and controller-command channels of the burst splitter.
// slave is the splitter side; master is the user/controller side.
interface mem_burst_splitter_if;
  import mem_ctrl_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_W-1:0]      req_addr;
  logic                   req_write;
  logic [LEN_W-1:0]       req_len;
  logic                   req_done;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [ADDR_W-1:0]      cmd_addr;
  logic                   cmd_write;
  logic [BURST_LEN_W-1:0] cmd_burst_len;

  modport slave (
    input  req_valid, req_addr, req_write, req_len, cmd_ready,
    output req_ready, req_done, cmd_valid, cmd_addr, cmd_write, cmd_burst_len
  );

  modport master (
    output req_valid, req_addr, req_write, req_len, cmd_ready,
    input  req_ready, req_done, cmd_valid, cmd_addr, cmd_write, cmd_burst_len
  );

endinterface

// File: rtl/mem_burst_splitter_calc.sv
// Combinational burst sizing: smallest of remaining beats, MAX_BURST and the
// beats left before the next BOUNDARY-byte address boundary.
module mem_burst_calc
  import mem_ctrl_pkg::*;
#(
  parameter int MAX_BURST = 64,
  parameter int BOUNDARY  = 4096
) (
  input  logic [ADDR_W-1:0]  cur_addr,
  input  logic [LEN_W-1:0]   rem,
  output logic [CHUNK_W-1:0] chunk
);

  localparam logic [ADDR_W:0]   BND      = (ADDR_W+1)'(BOUNDARY);
  localparam logic [ADDR_W-1:0] BND_MASK = ADDR_W'(BOUNDARY - 1);
  localparam logic [ADDR_W:0]   MAX_B    = (ADDR_W+1)'(MAX_BURST);

  logic [ADDR_W:0] room;
  logic [ADDR_W:0] lim;

  // One extra bit so an address sitting exactly on a boundary yields a full BOUNDARY of room.
  always_comb begin
    room  = (BND - {1'b0, cur_addr & BND_MASK}) >> BEAT_SHIFT;
    lim   = {{(ADDR_W+1-LEN_W){1'b0}}, rem};
    if (lim > MAX_B) lim = MAX_B;
    if (room < lim)  lim = room;
    chunk = lim[CHUNK_W-1:0];
  end

endmodule

// File: rtl/mem_burst_splitter.sv
// Splits user requests into controller bursts bounded by MAX_BURST and BOUNDARY.
// Gated by calibration_done; any controller error parks the FSM in HALT until reset.
module mem_burst_splitter
  import mem_ctrl_pkg::*;
#(
  parameter int MAX_BURST = 64,
  parameter int BOUNDARY  = 4096
) (
  input  logic                clk_mem,
  input  logic                rst_n,
  input  logic                calibration_done,
  input  logic                error,
  output logic                busy,
  output logic                err_halt,
  mem_burst_splitter_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              dir_q, dir_d;
  logic              null_done_q, null_done_d;
  logic              err_halt_q, err_halt_d;

  logic [CHUNK_W-1:0] chunk;
  logic               req_ready_c;
  logic               cmd_fire;
  logic               last_fire;

  mem_burst_calc #(
    .MAX_BURST (MAX_BURST),
    .BOUNDARY  (BOUNDARY)
  ) u_calc (
    .cur_addr (cur_addr_q),
    .rem      (rem_q),
    .chunk    (chunk)
  );

  always_ff @(posedge clk_mem or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      null_done_q <= 1'b0;
      err_halt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      null_done_q <= null_done_d;
      err_halt_q  <= err_halt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    null_done_d = 1'b0;
    err_halt_d  = err_halt_q | error;
    last_fire   = 1'b0;
    req_ready_c = (state_q == ST_IDLE) && calibration_done && !err_halt_q;
    cmd_fire    = (state_q == ST_ISSUE) && bus.cmd_ready;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_c) begin
          cur_addr_d = bus.req_addr & ~ADDR_W'(BEAT_BYTES - 1);
          rem_d      = bus.req_len;
          dir_d      = bus.req_write;
          if (bus.req_len == '0) null_done_d = 1'b1;
          else                   state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_fire) begin
          cur_addr_d = cur_addr_q + (ADDR_W'(chunk) << BEAT_SHIFT);
          rem_d      = rem_q - LEN_W'(chunk);
          if (rem_q == LEN_W'(chunk)) begin
            state_d   = ST_IDLE;
            last_fire = 1'b1;
          end
        end
      end
      ST_HALT: ;
      default: state_d = ST_HALT;
    endcase

    // Abort wins over everything except the address/remaining update of a coincident handshake.
    if (error) begin
      state_d     = ST_HALT;
      null_done_d = 1'b0;
    end
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.req_done      = null_done_q | (last_fire & ~error);
  assign bus.cmd_valid     = (state_q == ST_ISSUE);
  assign bus.cmd_addr      = cur_addr_q;
  assign bus.cmd_write     = dir_q;
  assign bus.cmd_burst_len = (state_q == ST_ISSUE) ? beats_to_len(chunk) : '0;
  assign busy              = (state_q == ST_ISSUE);
  assign err_halt          = err_halt_q;

endmodule

// File: tb/tb_mem_burst_splitter.sv
// Scoreboard bench for mem_burst_splitter: a reference splitter pushes expected
// commands at request acceptance; a monitor pops and compares on every handshake.
module tb_mem_burst_splitter;
  import mem_ctrl_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        wr;
    logic        last;
  } exp_t;

  logic clk_mem = 1'b0;
  logic rst_n;
  logic calibration_done;
  logic error;
  logic busy;
  logic err_halt;

  mem_burst_splitter_if bus();

  mem_burst_splitter #(.MAX_BURST(64), .BOUNDARY(4096)) dut (
    .clk_mem          (clk_mem),
    .rst_n            (rst_n),
    .calibration_done (calibration_done),
    .error            (error),
    .busy             (busy),
    .err_halt         (err_halt),
    .bus              (bus)
  );

  always #5 clk_mem = ~clk_mem;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   hs_cnt    = 0;
  int   done_cnt  = 0;
  bit   rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference split: walk the request beat budget independently of the DUT.
  task automatic push_model(input logic [31:0] addr, input int len, input logic wr);
    logic [31:0] a;
    int r, room, c;
    exp_t e;
    a = addr & 32'hFFFF_FFF0;
    r = len;
    while (r > 0) begin
      room = int'((32'd4096 - (a % 32'd4096)) / 32'd16);
      c = r;
      if (c > 64)   c = 64;
      if (c > room) c = room;
      e.addr = a;
      e.len  = 8'(c - 1);
      e.wr   = wr;
      e.last = (r == c);
      sb_q.push_back(e);
      a = a + 32'(c * 16);
      r = r - c;
    end
  endtask

  task automatic send_req(input logic [31:0] addr, input int len, input logic wr, input bit model);
    bit ok;
    ok = 1'b0;
    @(posedge clk_mem); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = 16'(len);
    bus.req_write = wr;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_mem);
      if (bus.req_ready) begin
        if (model) push_model(addr, len, wr);
        ok = 1'b1;
        break;
      end
      @(posedge clk_mem); #1;
      if (rnd_ready) bus.cmd_ready = 1'($urandom_range(0, 1));
    end
    if (ok) begin
      @(posedge clk_mem); #1;
    end else begin
      chk("req_accept_timeout", 0, 1);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_mem); #1;
      if (rnd_ready) bus.cmd_ready = 1'($urandom_range(0, 1));
      @(negedge clk_mem);
      if (!busy && sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk(tag, 0, 1);
      sb_q.delete();
    end
  endtask

  always @(negedge clk_mem) begin
    if (rst_n) begin
      if (bus.req_done) done_cnt++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_cmd", {32'd0, bus.cmd_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("cmd_addr",      bus.cmd_addr,      e.addr);
          chk("cmd_burst_len", bus.cmd_burst_len, e.len);
          chk("cmd_write",     bus.cmd_write,     e.wr);
          chk("req_done_at_hs", bus.req_done,     e.last);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, d0;
    rst_n            = 1'b0;
    calibration_done = 1'b0;
    error            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_addr     = '0;
    bus.req_len      = '0;
    bus.req_write    = 1'b0;
    bus.cmd_ready    = 1'b0;

    repeat (3) @(posedge clk_mem);
    @(negedge clk_mem);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd_addr",  bus.cmd_addr, 0);
    chk("rst_cmd_write", bus.cmd_write, 0);
    chk("rst_burst_len", bus.cmd_burst_len, 0);
    chk("rst_req_done",  bus.req_done, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_err_halt",  err_halt, 0);
    @(posedge clk_mem); #1;
    rst_n = 1'b1;

    // Calibration gate
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_len   = 16'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_mem);
      chk("gate_req_ready", bus.req_ready, 0);
      chk("gate_busy", busy, 0);
    end
    @(posedge clk_mem); #1;
    bus.req_valid    = 1'b0;
    calibration_done = 1'b1;

    // Null request
    d0 = done_cnt;
    h0 = hs_cnt;
    send_req(32'h100, 0, 1'b0, 1'b1);
    @(negedge clk_mem);
    chk("null_req_done", bus.req_done, 1);
    chk("null_cmd_valid", bus.cmd_valid, 0);
    @(negedge clk_mem);
    chk("null_req_done_end", bus.req_done, 0);
    chk("null_busy", busy, 0);
    chk("null_done_cnt", done_cnt - d0, 1);
    chk("null_hs_cnt", hs_cnt - h0, 0);

    // Plain split, boundary crossing and address wrap
    bus.cmd_ready = 1'b1;
    d0 = done_cnt;
    h0 = hs_cnt;
    send_req(32'h0, 200, 1'b1, 1'b1);
    wait_idle("split_timeout");
    chk("split_hs_cnt", hs_cnt - h0, 4);
    chk("split_done_cnt", done_cnt - d0, 1);

    h0 = hs_cnt;
    send_req(32'h0FC0, 10, 1'b0, 1'b1);
    wait_idle("bnd_timeout");
    chk("bnd_hs_cnt", hs_cnt - h0, 2);

    h0 = hs_cnt;
    send_req(32'hFFFF_FFE0, 4, 1'b1, 1'b1);
    wait_idle("wrap_timeout");
    chk("wrap_hs_cnt", hs_cnt - h0, 2);

    // Backpressure hold
    bus.cmd_ready = 1'b0;
    d0 = done_cnt;
    h0 = hs_cnt;
    send_req(32'h2000, 8, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_mem);
      chk("bp_cmd_valid", bus.cmd_valid, 1);
      chk("bp_cmd_addr", bus.cmd_addr, 32'h2000);
      chk("bp_burst_len", bus.cmd_burst_len, 7);
    end
    @(posedge clk_mem); #1;
    bus.cmd_ready = 1'b1;
    wait_idle("bp_timeout");
    chk("bp_hs_cnt", hs_cnt - h0, 1);
    chk("bp_done_cnt", done_cnt - d0, 1);

    // Back-to-back requests under random backpressure
    rnd_ready = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      send_req($urandom, int'($urandom_range(1, 300)), 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_idle("rnd_timeout");
    rnd_ready = 1'b0;
    chk("rnd_done_cnt", done_cnt - d0, 4);

    // Error abort during the second burst
    bus.cmd_ready = 1'b0;
    d0 = done_cnt;
    h0 = hs_cnt;
    sb_q.push_back('{addr: 32'h0, len: 8'd63, wr: 1'b1, last: 1'b0});
    send_req(32'h0, 200, 1'b1, 1'b0);
    @(negedge clk_mem);
    chk("err_first_valid", bus.cmd_valid, 1);
    @(posedge clk_mem); #1;
    bus.cmd_ready = 1'b1;
    @(posedge clk_mem); #1;
    bus.cmd_ready = 1'b0;
    @(negedge clk_mem);
    chk("err_second_valid", bus.cmd_valid, 1);
    chk("err_second_addr", bus.cmd_addr, 32'h400);
    @(posedge clk_mem); #1;
    error = 1'b1;
    @(posedge clk_mem); #1;
    error = 1'b0;
    @(negedge clk_mem);
    chk("err_cmd_valid", bus.cmd_valid, 0);
    chk("err_halt_set", err_halt, 1);
    chk("err_busy", busy, 0);
    bus.req_valid = 1'b1;
    bus.req_len   = 16'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_mem);
      chk("halt_req_ready", bus.req_ready, 0);
      chk("halt_req_done", bus.req_done, 0);
      chk("halt_cmd_valid", bus.cmd_valid, 0);
    end
    chk("err_done_cnt", done_cnt - d0, 0);
    chk("err_hs_cnt", hs_cnt - h0, 1);
    @(posedge clk_mem); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst2_err_halt", err_halt, 0);
    chk("rst2_cmd_valid", bus.cmd_valid, 0);
    chk("rst2_busy", busy, 0);
    @(posedge clk_mem); #1;
    rst_n = 1'b1;
    @(negedge clk_mem);
    chk("rst2_req_ready", bus.req_ready, 1);

    bus.cmd_ready = 1'b1;
    d0 = done_cnt;
    send_req(32'h0000_001C, 1, 1'b0, 1'b1);
    wait_idle("recover_timeout");
    chk("recover_done_cnt", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_burst_splitter.md
Name: mem_burst_splitter

Overview:
- Sits directly upstream of memory_controller and drives its command channel (cmd_addr / cmd_write / cmd_burst_len / cmd_ready).
- Accepts arbitrary-length user requests, counted in 16-byte beats (one beat = one 16-bit wr_strobe word).
- Splits each request into controller bursts that never exceed MAX_BURST beats and never cross a BOUNDARY-byte address boundary.
- Gates traffic on calibration_done and halts on controller error.

Parameters:
- MAX_BURST, 64, maximum beats per issued command; legal range 1..256.
- BOUNDARY, 4096, byte boundary a burst may not cross; power of two, at least BEAT_BYTES.
- BEAT_BYTES, 16, bytes per beat; fixed, from package.

Ports:
- clk_mem  in  1  memory clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  user request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  32  byte address; bits [3:0] ignored (treated as 0).
- req_write  in  1  1 = write, 0 = read.
- req_len  in  16  beats requested; 0 = null request.
- req_done  out  1  one-cycle pulse when the last command of a request is accepted.
- calibration_done  in  1  from controller.
- error  in  1  from controller.
- cmd_valid  out  1  command valid to controller.
- cmd_ready  in  1  controller accepts the command.
- cmd_addr  out  32  burst start byte address, bits [3:0] = 0.
- cmd_write  out  1  burst direction.
- cmd_burst_len  out  8  beats minus 1.
- busy  out  1  high while a request is in flight.
- err_halt  out  1  sticky; set when error is seen.

Behaviour:
- Reset values: req_ready=0, cmd_valid=0, cmd_addr=0, cmd_write=0, cmd_burst_len=0, req_done=0, busy=0, err_halt=0.
- Reset mid-operation discards all state immediately.
- FSM states: IDLE, ISSUE, HALT.
- IDLE:
  - req_ready = calibration_done && !err_halt (combinational from state and inputs).
  - On acceptance, latch cur_addr = {req_addr[31:4],4'b0}, rem = req_len, and dir.
  - If req_len == 0: stay in IDLE, pulse req_done next cycle, issue no command.
  - Otherwise go to ISSUE; busy=1 and cmd_valid=1 from the next cycle (one cycle of latency).
- Chunk computation:
  - chunk = min(rem, MAX_BURST, (BOUNDARY - (cur_addr mod BOUNDARY)) / BEAT_BYTES).
  - Computed from registers only, so it is stable while cmd_valid is held.
  - cmd_burst_len = chunk - 1; cmd_addr = cur_addr.
- ISSUE:
  - cmd_valid is held high. cmd_addr, cmd_write and cmd_burst_len stay constant until cmd_valid && cmd_ready.
  - On handshake: cur_addr += chunk*BEAT_BYTES (mod 2^32; wrap 0xFFFF_FFF0 -> 0 is legal), and rem -= chunk.
  - If rem == chunk: pulse req_done in the same cycle as the handshake, go to IDLE, drop cmd_valid, and deassert busy next cycle.
  - Otherwise stay in ISSUE and present the next burst the following cycle. One-cycle cmd_valid gap between bursts is permitted, not required.
- Back-to-back requests: req_ready may assert in the first IDLE cycle after req_done.
- calibration_done deassert while in ISSUE: ignored; the current request completes. It blocks only new acceptance.
- error=1 in any state:
  - Next state is HALT, err_halt=1, and cmd_valid=0 next cycle. Abort overrides the valid-hold rule.
  - In-flight request dropped without req_done.
  - HALT is exited only by reset.
- error and cmd handshake in the same cycle: the handshake counts (address/rem update), but the FSM still goes to HALT.
- Arithmetic: rem is 16 bits; chunk is 9 bits (max 256). Burst-length encoding is minus-one, so 256 beats → 8'hFF.

Decomposition:
- Package mem_ctrl_pkg: BEAT_BYTES, ADDR_W=32, LEN_W=16, BURST_LEN_W=8, FSM state typedef, function beats_to_len(beats) returning the minus-one encoding.
- Sub-module mem_burst_calc: combinational chunk computation (cur_addr, rem → chunk), unit-testable alone.

Test Plan:
- Plain split: addr 0x0, len 200, write, cmd_ready=1 → four commands.
  - Addrs 0x000/0x400/0x800/0xC00, burst_len 63/63/63/7.
  - req_done once, coincident with the 4th handshake.
- Boundary crossing: addr 0x0FC0, len 10 → cmd (0x0FC0, 3) then (0x1000, 5).
- Address wrap: addr 0xFFFF_FFE0, len 4 → cmd (0xFFFF_FFE0, 1) then (0x0000_0000, 1).
- Backpressure: cmd_ready held low 5 cycles during a burst → cmd_valid/addr/len stable all 5 cycles; exactly one handshake counted.
- Gating and null request:
  - calibration_done=0 with req_valid=1 → req_ready stays 0.
  - After calibration, len 0 → accepted, req_done pulse, no cmd_valid.
- Error abort: error pulsed during the 2nd burst of a len-200 request → cmd_valid=0 next cycle, err_halt=1, no req_done, req_ready=0 until rst_n low.
